// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-lane RAM with 1-cycle loads plus an optional MMIO window.
// Define DMEM_MMIO_EN to enable the MMIO window (addr >= IO_BASE) and the IO_WAIT state.
//
// state   | meaning
// IDLE    | ready; RAM accesses complete here, MMIO accesses launch from here
// IO_WAIT | io_req held, waiting for io_ack
module data_mem_responder #(
   parameter int          SCALE   = 12,
   parameter logic [31:0] IO_BASE = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic [3:0]  mem_oe,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_we,
   output logic [31:0] mem_rdata,
   output logic        mem_valid,
   output logic        mem_ready,
   output logic        io_req,
   output logic [31:0] io_addr,
   output logic [31:0] io_wdata,
   output logic [3:0]  io_we,
   input  logic [31:0] io_rdata,
   input  logic        io_ack
);

   typedef enum logic {IDLE, IO_WAIT} state_t;

   state_t      state_q, state_d;
   logic        io_req_q, io_req_d;
   logic [31:0] io_addr_q, io_addr_d;
   logic [31:0] io_wdata_q, io_wdata_d;
   logic [3:0]  io_we_q, io_we_d;
   logic        io_load_q, io_load_d;
   logic [1:0]  io_off_q, io_off_d;
   logic        mem_valid_q, mem_valid_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;

   logic [31:0]      ram_q [0:(2**SCALE)-1];
   logic [SCALE-1:0] ram_idx;
   logic [31:0]      ram_rdata;
   logic             ram_we;
   logic [1:0]       off;
   logic [3:0]       we_sh;
   logic [31:0]      wdata_sh;
   logic             is_io;
   logic             accept;

   assign off      = mem_addr[1:0];
   assign we_sh    = mem_we << off;
   assign wdata_sh = mem_wdata << {off, 3'b000};
   assign ram_idx  = mem_addr[2 +: SCALE];
   assign ram_rdata = ram_q[ram_idx];

`ifdef DMEM_MMIO_EN
   assign is_io     = (mem_addr >= IO_BASE);
   assign mem_ready = (state_q == IDLE);
`else
   localparam logic unused_io_base = |IO_BASE;
   assign is_io     = 1'b0;
   assign mem_ready = 1'b1;
`endif

   assign accept = mem_ready && (|mem_oe);

   always_comb begin
      state_d     = state_q;
      io_req_d    = io_req_q;
      io_addr_d   = io_addr_q;
      io_wdata_d  = io_wdata_q;
      io_we_d     = io_we_q;
      io_load_d   = io_load_q;
      io_off_d    = io_off_q;
      mem_valid_d = 1'b0;
      mem_rdata_d = mem_rdata_q;
      ram_we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_io) begin
                  state_d    = IO_WAIT;
                  io_req_d   = 1'b1;
                  io_addr_d  = {mem_addr[31:2], 2'b00};
                  io_wdata_d = wdata_sh;
                  io_we_d    = we_sh;
                  io_load_d  = ~|mem_we;
                  io_off_d   = off;
               end else if (|mem_we) begin
                  ram_we = 1'b1;
               end else begin
                  mem_valid_d = 1'b1;
                  mem_rdata_d = ram_rdata >> {off, 3'b000};
               end
            end
         end
         default: begin
            if (io_ack) begin
               state_d  = IDLE;
               io_req_d = 1'b0;
               if (io_load_q) begin
                  mem_valid_d = 1'b1;
                  mem_rdata_d = io_rdata >> {io_off_q, 3'b000};
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         io_req_q    <= 1'b0;
         io_addr_q   <= '0;
         io_wdata_q  <= '0;
         io_we_q     <= '0;
         io_load_q   <= 1'b0;
         io_off_q    <= '0;
         mem_valid_q <= 1'b0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         io_req_q    <= io_req_d;
         io_addr_q   <= io_addr_d;
         io_wdata_q  <= io_wdata_d;
         io_we_q     <= io_we_d;
         io_load_q   <= io_load_d;
         io_off_q    <= io_off_d;
         mem_valid_q <= mem_valid_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // RAM is never cleared by reset; stores during the reset cycle are dropped.
   always_ff @(posedge clk) begin
      if (ram_we && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (we_sh[b]) ram_q[ram_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   assign mem_valid = mem_valid_q;
   assign mem_rdata = mem_rdata_q;
   assign io_req    = io_req_q;
   assign io_addr   = io_addr_q;
   assign io_wdata  = io_wdata_q;
   assign io_we     = io_we_q;

endmodule
